fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage with PC, 1-cycle imem interface, stall hold buffer and IF/ID register
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   initial_address                PC value loaded on reset
//   tr                             run enable for new fetches
//   imem_addr, imem_req            fetch address and read strobe
//   imem_rdata                     instruction for last cycle's request
//   stall_d                        decode stall, IF/ID holds
//   redirect_e, redirect_target    taken branch/jump from EX
//   ifid_pc, ifid_pc4              PC of IF/ID instruction and PC+4
//   ifid_instr, ifid_valid         IF/ID instruction and valid flag
module fetch_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] initial_address,
    input  logic            tr,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [XLEN-1:0] ifid_instr,
    output logic            ifid_valid
);
    logic [XLEN-1:0] pc, tag, hb_instr, hb_pc;
    logic            inflight, hb_valid;

    assign imem_addr = pc;
    // The hold buffer only fills while stalled and always drains on the first
    // unstalled edge, so a fetch may issue in that same cycle without its
    // return ever colliding with a valid buffer.
    assign imem_req = tr & ~stall_d & ~redirect_e & ~reset;
    assign ifid_pc4 = ifid_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= initial_address;
            tag        <= '0;
            inflight   <= 1'b0;
            hb_valid   <= 1'b0;
            hb_instr   <= NOP;
            hb_pc      <= '0;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req)
                tag <= pc;
            if (redirect_e) begin
                pc         <= {redirect_target[XLEN-1:2], 2'b00};
                hb_valid   <= 1'b0;
                ifid_instr <= NOP;
                ifid_valid <= 1'b0;
            end else begin
                if (imem_req)
                    pc <= pc + XLEN'(4);
                if (stall_d) begin
                    if (inflight) begin
                        hb_valid <= 1'b1;
                        hb_instr <= imem_rdata;
                        hb_pc    <= tag;
                    end
                end else if (hb_valid) begin
                    hb_valid   <= 1'b0;
                    ifid_pc    <= hb_pc;
                    ifid_instr <= hb_instr;
                    ifid_valid <= 1'b1;
                end else if (inflight) begin
                    ifid_pc    <= tag;
                    ifid_instr <= imem_rdata;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_instr <= NOP;
                    ifid_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random check of fetch_stage against a fetch-queue reference model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, tr, stall_d, redirect_e, imem_req, ifid_valid;
    logic [31:0] initial_address, redirect_target, imem_rdata, imem_addr;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: next fetch address, plus the ordered list of fetched
    // PCs (with their issue cycle) not yet delivered to decode.
    logic [31:0] mpc, e_pc, e_instr;
    logic        e_valid;
    logic [31:0] q_pc[$];
    int          q_cyc[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .initial_address(initial_address), .tr(tr),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect_e(redirect_e), .redirect_target(redirect_target),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a is ~a, one-cycle latency.
    always @(posedge clk) imem_rdata <= ~imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit s, input bit d, input logic [31:0] tgt);
        bit issue;
        reset = r;
        tr = t;
        stall_d = s;
        redirect_e = d;
        redirect_target = tgt;
        issue = !r && t && !s && !d;
        #1;
        check("imem_req", {31'b0, imem_req}, {31'b0, issue});
        if (issue)
            check("imem_addr", imem_addr, mpc);
        if (r) begin
            mpc = initial_address;
            q_pc.delete();
            q_cyc.delete();
            e_pc = 32'h0;
            e_instr = NOP;
            e_valid = 1'b0;
        end else if (d) begin
            q_pc.delete();
            q_cyc.delete();
            mpc = {tgt[31:2], 2'b00};
            e_instr = NOP;
            e_valid = 1'b0;
        end else begin
            if (!s) begin
                // Oldest fetch whose data has already returned is delivered.
                if (q_pc.size() > 0 && q_cyc[0] < cyc) begin
                    e_pc = q_pc.pop_front();
                    void'(q_cyc.pop_front());
                    e_instr = ~e_pc;
                    e_valid = 1'b1;
                end else begin
                    e_instr = NOP;
                    e_valid = 1'b0;
                end
            end
            if (issue) begin
                q_pc.push_back(mpc);
                q_cyc.push_back(cyc);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e_valid});
        check("ifid_pc", ifid_pc, e_pc);
        check("ifid_pc4", ifid_pc4, e_pc + 32'd4);
        check("ifid_instr", ifid_instr, e_instr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        tr = 1'b0;
        stall_d = 1'b0;
        redirect_e = 1'b0;
        redirect_target = 32'h0;
        initial_address = 32'h0;
        imem_rdata = 32'h0;

        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        cyc = 0;
        run(5);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h0);
        run(4);

        step(0, 1, 1, 1, 32'h100);
        run(5);
        step(0, 1, 0, 1, 32'h103);
        run(5);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0);
        run(4);

        initial_address = 32'hFFFF_FFF8;
        step(1, 1, 0, 0, 32'h0);
        run(6);

        run(2);
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        initial_address = 32'h0000_0040;
        step(1, 1, 1, 0, 32'h0);
        run(5);

        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom % 50) == 0;
            if (r)
                initial_address = ($urandom % 2) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(r, ($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 10) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
